// File: rtl/rf_op_sequencer.sv
// Single-issue register-file operation sequencer: accepts one command, reads its two
// source registers, computes an ALU result and writes it back over four cycles.
module rf_op_sequencer #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        op,
    input  logic [ADDR_W-1:0] rd,
    input  logic [ADDR_W-1:0] rs,
    input  logic [ADDR_W-1:0] rt,
    input  logic [DATA_W-1:0] imm,
    output logic              WEN,
    output logic [ADDR_W-1:0] RW,
    output logic [DATA_W-1:0] busW,
    output logic [ADDR_W-1:0] RX,
    output logic [ADDR_W-1:0] RY,
    input  logic [DATA_W-1:0] busX,
    input  logic [DATA_W-1:0] busY,
    output logic              done,
    output logic [DATA_W-1:0] result,
    output logic              ovf
);

    typedef enum logic [1:0] {
        IDLE,
        READ,
        EXEC,
        WRITE
    } stateT;

    typedef enum logic [2:0] {
        OP_ADD = 3'd0,
        OP_SUB = 3'd1,
        OP_AND = 3'd2,
        OP_OR  = 3'd3,
        OP_XOR = 3'd4,
        OP_SLT = 3'd5,
        OP_MOV = 3'd6,
        OP_LI  = 3'd7
    } opT;

    localparam int MSB = DATA_W - 1;

    stateT             state;
    stateT             nextState;
    logic              accept;

    opT                opReg;
    logic [ADDR_W-1:0] rdReg;
    logic [DATA_W-1:0] immReg;
    logic [DATA_W-1:0] xReg;
    logic [DATA_W-1:0] yReg;

    logic [DATA_W-1:0] sum;
    logic [DATA_W-1:0] diff;
    logic              sltBit;
    logic [DATA_W-1:0] aluVal;
    logic              aluOvf;

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    // NOTE: state registers use non-blocking (<=) so every flop samples the
    // pre-edge value of its neighbours; blocking here would create order-
    // dependent simulation that no longer matches the synthesized flops.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // NOTE: every output of this block gets a default before the case, so no
    // path leaves a signal unassigned and no latch is inferred.
    always_comb begin
        nextState = state;
        in_ready  = 1'b0;
        WEN       = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    nextState = READ;
                end
            end
            READ:    nextState = EXEC;
            EXEC:    nextState = WRITE;
            WRITE: begin
                WEN       = 1'b1;
                done      = 1'b1;
                nextState = IDLE;
            end
            default: nextState = IDLE;
        endcase
    end

    assign accept = in_valid && in_ready;

    // ------------------------------------------------------------------
    // Command and operand capture
    // ------------------------------------------------------------------
    // NOTE: these registers carry no reset: each is always loaded (on accept
    // or in READ) before anything reads it, and reset only ever returns the
    // FSM to IDLE, so their stale contents can never reach an output.
    always_ff @(posedge Clk) begin
        if (accept) begin
            opReg  <= opT'(op);
            rdReg  <= rd;
            immReg <= imm;
        end
        if (state == READ) begin
            xReg <= busX;
            yReg <= busY;
        end
    end

    // ------------------------------------------------------------------
    // ALU on captured operands
    // ------------------------------------------------------------------
    assign sum    = xReg + yReg;
    assign diff   = xReg - yReg;
    assign sltBit = $signed(xReg) < $signed(yReg);

    always_comb begin
        aluVal = '0;
        aluOvf = 1'b0;
        case (opReg)
            OP_ADD: begin
                aluVal = sum;
                aluOvf = (xReg[MSB] == yReg[MSB]) && (sum[MSB] != xReg[MSB]);
            end
            OP_SUB: begin
                aluVal = diff;
                aluOvf = (xReg[MSB] != yReg[MSB]) && (diff[MSB] != xReg[MSB]);
            end
            OP_AND:  aluVal = xReg & yReg;
            OP_OR:   aluVal = xReg | yReg;
            OP_XOR:  aluVal = xReg ^ yReg;
            OP_SLT:  aluVal = {{(DATA_W-1){1'b0}}, sltBit};
            OP_MOV:  aluVal = xReg;
            OP_LI:   aluVal = immReg;
            default: aluVal = '0;
        endcase
    end

    // ------------------------------------------------------------------
    // Register-file ports and visible result
    // ------------------------------------------------------------------
    // Read addresses are loaded on accept so they are already stable for the
    // whole READ cycle; write address/data and result land as WRITE begins.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            RX     <= '0;
            RY     <= '0;
            RW     <= '0;
            busW   <= '0;
            result <= '0;
            ovf    <= 1'b0;
        end else begin
            if (accept) begin
                RX <= rs;
                RY <= rt;
            end
            if (state == EXEC) begin
                RW     <= rdReg;
                busW   <= aluVal;
                result <= aluVal;
                ovf    <= aluOvf;
            end
        end
    end

endmodule

// File: tb/tb_rf_op_sequencer.sv
// Scoreboard bench for rf_op_sequencer: directed commands against a behavioural
// register file, with write-backs checked by an independent monitor.
module tb_rf_op_sequencer;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 3;

    typedef struct packed {
        logic [ADDR_W-1:0] rd;
        logic [DATA_W-1:0] data;
        logic              ovf;
    } expT;

    logic              Clk = 1'b0;
    logic              Rst = 1'b1;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [2:0]        op = '0;
    logic [ADDR_W-1:0] rd = '0;
    logic [ADDR_W-1:0] rs = '0;
    logic [ADDR_W-1:0] rt = '0;
    logic [DATA_W-1:0] imm = '0;
    logic              WEN;
    logic [ADDR_W-1:0] RW;
    logic [DATA_W-1:0] busW;
    logic [ADDR_W-1:0] RX;
    logic [ADDR_W-1:0] RY;
    logic [DATA_W-1:0] busX;
    logic [DATA_W-1:0] busY;
    logic              done;
    logic [DATA_W-1:0] result;
    logic              ovf;

    int checks = 0;
    int failures = 0;
    expT expQ[$];

    logic [DATA_W-1:0] rf [2**ADDR_W] = '{default: 8'h00};

    always #5 Clk = ~Clk;

    rf_op_sequencer #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .Clk(Clk), .Rst(Rst), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .rd(rd), .rs(rs), .rt(rt), .imm(imm),
        .WEN(WEN), .RW(RW), .busW(busW), .RX(RX), .RY(RY),
        .busX(busX), .busY(busY), .done(done), .result(result), .ovf(ovf)
    );

    // Behavioural register file: combinational read, r0 hard-wired to zero.
    assign busX = rf[RX];
    assign busY = rf[RY];
    always @(posedge Clk) begin
        if (WEN && RW != '0) rf[RW] <= busW;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every write-back pops one expectation.
    initial begin
        expT e;
        forever begin
            @(negedge Clk);
            if (WEN || done) begin
                check("wen_eq_done", 32'(WEN), 32'(done));
                if (expQ.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_writeback: RW=%0d busW=0x%0h with nothing expected", RW, busW);
                end else begin
                    e = expQ.pop_front();
                    check("wb_rw", 32'(RW), 32'(e.rd));
                    check("wb_busw", 32'(busW), 32'(e.data));
                    check("wb_result", 32'(result), 32'(e.data));
                    check("wb_ovf", 32'(ovf), 32'(e.ovf));
                end
            end
        end
    end

    task automatic issue(input logic [2:0] o, input logic [2:0] d, input logic [2:0] s,
                         input logic [2:0] t, input logic [7:0] i, input logic expect_wb,
                         input logic [7:0] exp_data, input logic exp_ovf);
        int n;
        @(negedge Clk);
        op = o; rd = d; rs = s; rt = t; imm = i;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge Clk);
            n++;
        end
        if (!in_ready) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout: in_ready=0 expected 1 within 50 cycles");
            in_valid = 1'b0;
        end else begin
            if (expect_wb) expQ.push_back('{rd: d, data: exp_data, ovf: exp_ovf});
            @(posedge Clk);
            #1 in_valid = 1'b0;
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (expQ.size() != 0 && n < 100) begin
            @(negedge Clk);
            n++;
        end
        check("drain_pending", 32'(expQ.size()), 32'd0);
        repeat (2) @(negedge Clk);
    endtask

    localparam logic [2:0] ADD = 3'd0, SUB = 3'd1, AND_ = 3'd2, OR_ = 3'd3,
                           XOR_ = 3'd4, SLT = 3'd5, MOV = 3'd6, LI = 3'd7;

    initial begin
        int acc, dn, wn;

        // Reset with a valid command present: reset must win.
        in_valid = 1'b1; op = LI; rd = 3'd7; imm = 8'hEE;
        repeat (3) @(posedge Clk);
        @(negedge Clk);
        Rst = 1'b0;
        in_valid = 1'b0;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_wen", 32'(WEN), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_result", 32'(result), 32'd0);
        check("rst_ovf", 32'(ovf), 32'd0);
        check("rst_rw", 32'(RW), 32'd0);
        check("rst_rx", 32'(RX), 32'd0);
        check("rst_ry", 32'(RY), 32'd0);
        check("rst_busw", 32'(busW), 32'd0);

        // Immediates, signed overflow, SLT, self-dependency, logic ops.
        issue(LI,   3'd1, 3'd0, 3'd0, 8'h7F, 1'b1, 8'h7F, 1'b0);
        issue(LI,   3'd2, 3'd0, 3'd0, 8'h01, 1'b1, 8'h01, 1'b0);
        issue(ADD,  3'd3, 3'd1, 3'd2, 8'h00, 1'b1, 8'h80, 1'b1);
        issue(SUB,  3'd4, 3'd2, 3'd1, 8'h00, 1'b1, 8'h82, 1'b0);
        issue(SLT,  3'd5, 3'd3, 3'd2, 8'h00, 1'b1, 8'h01, 1'b0);
        issue(SLT,  3'd5, 3'd2, 3'd3, 8'h00, 1'b1, 8'h00, 1'b0);
        issue(LI,   3'd6, 3'd0, 3'd0, 8'h21, 1'b1, 8'h21, 1'b0);
        issue(ADD,  3'd6, 3'd6, 3'd6, 8'h00, 1'b1, 8'h42, 1'b0);
        drain();
        check("rf_r6_selfdep", 32'(rf[6]), 32'h42);
        issue(SUB,  3'd4, 3'd3, 3'd2, 8'h00, 1'b1, 8'h7F, 1'b1);
        issue(AND_, 3'd0, 3'd1, 3'd3, 8'h00, 1'b1, 8'h00, 1'b0);
        issue(OR_,  3'd4, 3'd1, 3'd3, 8'h00, 1'b1, 8'hFF, 1'b0);
        issue(XOR_, 3'd5, 3'd1, 3'd2, 8'h00, 1'b1, 8'h7E, 1'b0);
        issue(MOV,  3'd6, 3'd3, 3'd0, 8'h00, 1'b1, 8'h80, 1'b0);
        drain();

        // in_valid held for ten cycles: accepts only at cycles 0, 4, 8.
        repeat (3) expQ.push_back('{rd: 3'd0, data: 8'h7F, ovf: 1'b0});
        @(negedge Clk);
        op = MOV; rd = 3'd0; rs = 3'd1; rt = 3'd0; imm = 8'h00;
        in_valid = 1'b1;
        acc = 0; dn = 0; wn = 0;
        for (int i = 0; i < 10; i++) begin
            check($sformatf("hold_ready_c%0d", i), 32'(in_ready), 32'((i % 4) == 0));
            if (in_ready) acc++;
            if (done) dn++;
            if (WEN) wn++;
            @(negedge Clk);
        end
        in_valid = 1'b0;
        check("hold_accepts", 32'(acc), 32'd3);
        check("hold_done_pulses", 32'(dn), 32'd2);
        check("hold_wen_pulses", 32'(wn), 32'd2);
        drain();

        // Reset during EXEC of LI r7,0xAA: the write must never happen.
        issue(LI, 3'd7, 3'd0, 3'd0, 8'hAA, 1'b0, 8'h00, 1'b0);
        @(posedge Clk);
        @(negedge Clk);
        Rst = 1'b1;
        @(posedge Clk);
        #1 Rst = 1'b0;
        @(negedge Clk);
        check("abort_result", 32'(result), 32'd0);
        check("abort_ovf", 32'(ovf), 32'd0);
        check("abort_in_ready", 32'(in_ready), 32'd1);
        wn = 0;
        for (int i = 0; i < 8; i++) begin
            if (WEN) wn++;
            @(negedge Clk);
        end
        check("abort_no_wen", 32'(wn), 32'd0);

        // Final register-file contents.
        check("rf_r0", 32'(rf[0]), 32'h00);
        check("rf_r1", 32'(rf[1]), 32'h7F);
        check("rf_r2", 32'(rf[2]), 32'h01);
        check("rf_r3", 32'(rf[3]), 32'h80);
        check("rf_r4", 32'(rf[4]), 32'hFF);
        check("rf_r5", 32'(rf[5]), 32'h7E);
        check("rf_r6", 32'(rf[6]), 32'h80);
        check("rf_r7", 32'(rf[7]), 32'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish within time limit");
        $fatal(1, "timeout");
    end

endmodule
